display_multiplexado: RTL and testbench

Time-multiplexed driver for a parametrised bank of 7-segment digits. It holds a shadow register of packed 4-bit digit values and decimal points, and scans one digit at a time at a programmable rate. Each digit is decoded in BCD or hexadecimal mode, with optional leading-zero blanking. It sits between the decade/counter datapaths and the board's common-anode display pins, and replaces per-digit static decoders.

---
 rtl/display_multiplexado.sv | 142 ++++++++++++++
 tb/tb_display_multiplexado.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_multiplexado.sv
// display_multiplexado
// Time-multiplexed driver for a bank of 7-segment digits. A shadow register
// holds one nibble and one decimal point per digit. A prescaler keeps each
// digit lit for DIVISOR cycles, and the digit index then advances. The active
// nibble is decoded in BCD or hex mode. Leading zeros can be blanked.
//
// Ports
//   clock         system clock, rising edge
//   reset         synchronous, active-high
//   habilita      scan enable; when low, all outputs are inactive and the scan is frozen
//   carregar      strobe: latch valores/pontos into the shadow register
//   valores       packed nibbles, digit 0 in bits [3:0]
//   pontos        decimal point request per digit
//   modo_hex      0 = BCD (10..15 blank), 1 = hex
//   apagar_zeros  leading-zero blanking enable
//   segmentos     segments a..g, segmentos[0] = a
//   ponto         decimal point of the active digit
//   anodos        one-hot digit select
module display_multiplexado #(
    parameter int DIGITOS     = 4,
    parameter int DIVISOR     = 50000,
    parameter int ATIVO_BAIXO = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   habilita,
    input  logic                   carregar,
    input  logic [4*DIGITOS-1:0]   valores,
    input  logic [DIGITOS-1:0]     pontos,
    input  logic                   modo_hex,
    input  logic                   apagar_zeros,
    output logic [0:6]             segmentos,
    output logic                   ponto,
    output logic [DIGITOS-1:0]     anodos
);

    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int IW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;

    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [4*DIGITOS-1:0]   shadow_val;
    logic [DIGITOS-1:0]     shadow_pt;

    // The output registers are kept in active-low form internally. For
    // active-high boards, they are inverted after the flop, so reset always
    // yields "inactive".
    logic [0:6]             seg_q;
    logic                   pt_q;
    logic [DIGITOS-1:0]     an_q;

    logic [0:6]             seg_nxt;
    logic                   pt_nxt;
    logic [DIGITOS-1:0]     an_nxt;
    logic [3:0]             nibble;
    logic                   blank;
    logic                   zero_acc;
    logic [DIGITOS-1:0]     zeros_acima;

    function automatic logic [0:6] decodifica(input logic [3:0] v, input logic hex);
        logic [0:6] s;
        s = 7'b1111111;
        case (v)
            4'd0:  s = 7'b0000001;
            4'd1:  s = 7'b1001111;
            4'd2:  s = 7'b0010010;
            4'd3:  s = 7'b0000110;
            4'd4:  s = 7'b1001100;
            4'd5:  s = 7'b0100100;
            4'd6:  s = 7'b0100000;
            4'd7:  s = 7'b0001111;
            4'd8:  s = 7'b0000000;
            4'd9:  s = 7'b0000100;
            4'd10: s = hex ? 7'b0001000 : 7'b1111111;
            4'd11: s = hex ? 7'b1100000 : 7'b1111111;
            4'd12: s = hex ? 7'b0110001 : 7'b1111111;
            4'd13: s = hex ? 7'b1000010 : 7'b1111111;
            4'd14: s = hex ? 7'b0110000 : 7'b1111111;
            4'd15: s = hex ? 7'b0111000 : 7'b1111111;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        // zeros_acima[i] is set when nibble i and every nibble above it are zero
        zero_acc    = 1'b1;
        zeros_acima = '0;
        for (int i = DIGITOS - 1; i >= 0; i--) begin
            zero_acc       = zero_acc & (shadow_val[4*i +: 4] == 4'd0);
            zeros_acima[i] = zero_acc;
        end

        nibble  = shadow_val[4*idx +: 4];
        blank   = apagar_zeros && (idx != '0) && zeros_acima[idx];
        seg_nxt = blank ? 7'b1111111 : decodifica(nibble, modo_hex);
        pt_nxt  = ~shadow_pt[idx];
        an_nxt  = '1;
        for (int i = 0; i < DIGITOS; i++) begin
            an_nxt[i] = (idx != IW'(i));
        end

        if (!habilita) begin
            seg_nxt = '1;
            pt_nxt  = 1'b1;
            an_nxt  = '1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            shadow_val <= '0;
            shadow_pt  <= '0;
            seg_q      <= '1;
            pt_q       <= 1'b1;
            an_q       <= '1;
        end else begin
            if (carregar) begin
                shadow_val <= valores;
                shadow_pt  <= pontos;
            end
            if (habilita) begin
                if (cnt == CW'(DIVISOR - 1)) begin
                    cnt <= '0;
                    idx <= (idx == IW'(DIGITOS - 1)) ? '0 : idx + IW'(1);
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
            seg_q <= seg_nxt;
            pt_q  <= pt_nxt;
            an_q  <= an_nxt;
        end
    end

    assign segmentos = (ATIVO_BAIXO != 0) ? seg_q : ~seg_q;
    assign ponto     = (ATIVO_BAIXO != 0) ? pt_q  : ~pt_q;
    assign anodos    = (ATIVO_BAIXO != 0) ? an_q  : ~an_q;

endmodule

// File: tb/tb_display_multiplexado.sv
// Bench for display_multiplexado. The main instance has 4 digits, a 4-cycle
// dwell and active-low outputs. A second instance has 1 digit, a 1-cycle
// dwell and active-high outputs.
module tb_display_multiplexado;

    localparam int DG = 4;
    localparam int DV = 4;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, habilita, carregar, modo_hex, apagar_zeros;
    logic [15:0] valores;
    logic [3:0]  pontos;
    logic [0:6]  segmentos;
    logic        ponto;
    logic [3:0]  anodos;

    logic        reset2, hab2, car2;
    logic [3:0]  val2;
    logic [0:0]  pts2;
    logic [0:6]  seg2;
    logic        pto2;
    logic [0:0]  an2;

    display_multiplexado #(.DIGITOS(DG), .DIVISOR(DV), .ATIVO_BAIXO(1)) dut (
        .clock(clock), .reset(reset), .habilita(habilita), .carregar(carregar),
        .valores(valores), .pontos(pontos), .modo_hex(modo_hex),
        .apagar_zeros(apagar_zeros), .segmentos(segmentos), .ponto(ponto),
        .anodos(anodos)
    );

    display_multiplexado #(.DIGITOS(1), .DIVISOR(1), .ATIVO_BAIXO(0)) dut_pol (
        .clock(clock), .reset(reset2), .habilita(hab2), .carregar(car2),
        .valores(val2), .pontos(pts2), .modo_hex(modo_hex),
        .apagar_zeros(apagar_zeros), .segmentos(seg2), .ponto(pto2),
        .anodos(an2)
    );

    int n_ok  = 0;
    int n_chk = 0;

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_chk++;
        if (obs === esp) n_ok++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    endtask

    // Reference decode, written from the segment table (active-low, a..g).
    function automatic logic [0:6] esp_seg(input int v, input logic hex);
        if (!hex && v > 9) return 7'b1111111;
        case (v)
            0:  return 7'b0000001;
            1:  return 7'b1001111;
            2:  return 7'b0010010;
            3:  return 7'b0000110;
            4:  return 7'b1001100;
            5:  return 7'b0100100;
            6:  return 7'b0100000;
            7:  return 7'b0001111;
            8:  return 7'b0000000;
            9:  return 7'b0000100;
            10: return 7'b0001000;
            11: return 7'b1100000;
            12: return 7'b0110001;
            13: return 7'b1000010;
            14: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    // Scoreboard: on each edge, the model predicts {anodos, segmentos, ponto}
    // from its state before the edge. It then updates its own state.
    logic [11:0] fila[$];
    int          m_idx = 0;
    int          m_cnt = 0;
    logic [15:0] m_sv  = '0;
    logic [3:0]  m_sp  = '0;

    always @(posedge clock) begin
        logic [11:0] e;
        logic [0:6]  s;
        logic        bl;
        if (reset) begin
            e = 12'hFFF;
            m_idx = 0; m_cnt = 0; m_sv = '0; m_sp = '0;
        end else begin
            if (habilita) begin
                bl = apagar_zeros && (m_idx > 0) && ((m_sv >> (4 * m_idx)) == 16'd0);
                s  = bl ? 7'b1111111 : esp_seg(int'(m_sv[4*m_idx +: 4]), modo_hex);
                e  = {4'hF & ~(4'b0001 << m_idx), s, ~m_sp[m_idx]};
            end else begin
                e = 12'hFFF;
            end
            if (carregar) begin
                m_sv = valores;
                m_sp = pontos;
            end
            if (habilita) begin
                if (m_cnt == DV - 1) begin
                    m_cnt = 0;
                    m_idx = (m_idx + 1) % DG;
                end else begin
                    m_cnt++;
                end
            end
        end
        fila.push_back(e);
    end

    always @(negedge clock) begin
        logic [11:0] e;
        if (fila.size() > 0) begin
            e = fila.pop_front();
            confere("sb", {anodos, segmentos, ponto}, e);
        end
    end

    logic [3:0] an_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Reset, load while disabled, then enable. Afterwards, check 17 cycles
    // of pins: 4 digits x 4 cycles each, plus the wrap back to digit 0.
    task automatic frame_check(input string tag, input logic [15:0] v, input logic [3:0] p,
                               input logic [0:6] s0, input logic [0:6] s1,
                               input logic [0:6] s2, input logic [0:6] s3,
                               input logic [3:0] pt_al);
        logic [0:6] ss [4];
        int d;
        ss[0] = s0; ss[1] = s1; ss[2] = s2; ss[3] = s3;
        reset = 1'b1; habilita = 1'b0;
        @(negedge clock);
        reset = 1'b0; carregar = 1'b1; valores = v; pontos = p;
        @(negedge clock);
        carregar = 1'b0; habilita = 1'b1;
        @(negedge clock);
        for (int k = 0; k <= 16; k++) begin
            d = (k / 4) % 4;
            confere({tag, "_an"},  anodos,    an_seq[d]);
            confere({tag, "_seg"}, segmentos, ss[d]);
            confere({tag, "_pt"},  ponto,     pt_al[d]);
            @(negedge clock);
        end
    endtask

    initial begin
        int cnt_d;
        reset = 1'b1; habilita = 1'b1; carregar = 1'b1; valores = 16'h1234; pontos = 4'hF;
        modo_hex = 1'b0; apagar_zeros = 1'b0;
        reset2 = 1'b1; hab2 = 1'b0; car2 = 1'b0; val2 = 4'h0; pts2 = 1'b0;

        // reset dominates both load and enable
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            confere("rst_an",  anodos,    4'b1111);
            confere("rst_seg", segmentos, 7'b1111111);
            confere("rst_pt",  ponto,     1'b1);
        end
        confere("pol_rst", {an2, seg2, pto2}, 9'h000);
        reset = 1'b0; carregar = 1'b0;
        @(negedge clock);
        confere("rel_an",  anodos,    4'b1110);
        confere("rel_seg", segmentos, 7'b0000001);

        frame_check("scan", 16'h4321, 4'h0, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 4'b1111);

        // habilita dropped during digit 2, cycle 2, then restored 5 cycles later
        for (int t = 0; t < 40 && !(m_idx == 2 && m_cnt == 2); t++) @(negedge clock);
        confere("wait_d2", (m_idx == 2 && m_cnt == 2), 1'b1);
        habilita = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            confere("dis_out", {anodos, segmentos, ponto}, 12'hFFF);
        end
        habilita = 1'b1;
        cnt_d = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (anodos == 4'b1011) cnt_d++;
        end
        confere("resume_d2", cnt_d, 2);

        // reset pulse during digit 3 restarts digit 0 with a full dwell
        for (int t = 0; t < 40 && m_idx != 3; t++) @(negedge clock);
        confere("wait_d3", m_idx, 3);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        cnt_d = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (anodos == 4'b1110) cnt_d++;
        end
        confere("rst_dwell", cnt_d, 4);

        modo_hex = 1'b1;
        frame_check("hex", 16'hFEDA, 4'h0, 7'b0001000, 7'b1000010, 7'b0110000, 7'b0111000, 4'b1111);
        modo_hex = 1'b0;
        frame_check("bcd", 16'hFEDA, 4'h0, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 4'b1111);

        apagar_zeros = 1'b1;
        frame_check("blank", 16'h0050, 4'b1000, 7'b0000001, 7'b0100100, 7'b1111111, 7'b1111111, 4'b0111);

        // mixed traffic, checked by the scoreboard alone
        for (int k = 0; k < 80; k++) begin
            carregar     = ($urandom_range(0, 3) == 0);
            valores      = 16'($urandom);
            pontos       = 4'($urandom);
            modo_hex     = 1'($urandom);
            apagar_zeros = 1'($urandom);
            habilita     = ($urandom_range(0, 4) != 0);
            @(negedge clock);
        end

        // active-high instance with a single digit
        reset2 = 1'b0; car2 = 1'b1; val2 = 4'h8; pts2 = 1'b1; hab2 = 1'b1;
        @(negedge clock);
        confere("pol_zero", {an2, seg2, pto2}, 9'b1_1111110_0);
        car2 = 1'b0;
        @(negedge clock);
        confere("pol_8", {an2, seg2, pto2}, 9'h1FF);
        reset2 = 1'b1;
        @(negedge clock);
        confere("pol_rst2", {an2, seg2, pto2}, 9'h000);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
